// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: owner encodings and a
// helper that sizes the hold counters.
package ram_bus_arbiter_pkg;

  localparam int OWNER_W = 2;

  typedef enum logic [OWNER_W-1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  // Width needed to hold values 0..limit-1 (never narrower than one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_hold.sv
// Saturating hold counter: counts up to LIMIT-1 and sticks there,
// clears on request, flags when the limit value has been reached.
module hold_counter
  import ram_bus_arbiter_pkg::*;
#(
  parameter  int LIMIT = 4,
  localparam int CNT_W = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == MAX_VAL);

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbiter for the single-port data RAM shared by the CPU data port and
// the DMAC. Registered owner, combinational grants and RAM mux, with
// bounded-hold fairness in both directions. A DMA read is always followed
// by its write before the bus can be taken away.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int MAX_DMA_BURST = 4,
  parameter int MAX_CPU_HOLD  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata
);

  owner_e owner_q;
  owner_e owner_d;
  logic   cpu_grant;
  logic   cpu_at_limit;
  logic   xfer_at_limit;
  logic   cpu_inc;
  logic   xfer_inc;
  logic   owner_change;

  // Next owner. The DMA side only hands over on a write cycle, so a
  // read/write pair always completes under the same tenure.
  // NOTE: owner_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (cpu_req)      owner_d = OWN_CPU;
        else if (dma_req) owner_d = OWN_DMA;
      end
      OWN_CPU: begin
        if (!cpu_req)                    owner_d = dma_req ? OWN_DMA : OWN_NONE;
        else if (dma_req && cpu_at_limit) owner_d = OWN_DMA;
      end
      OWN_DMA: begin
        if (!dma_req)                              owner_d = cpu_req ? OWN_CPU : OWN_NONE;
        else if (dma_we && cpu_req && xfer_at_limit) owner_d = OWN_CPU;
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  // Owner register; reset drops ownership even in the middle of a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Fairness accounting: cycles the CPU holds while DMA waits, and DMA
  // write cycles while the CPU waits. Both restart on every handoff.
  assign owner_change = (owner_d != owner_q);
  assign cpu_inc      = (owner_q == OWN_CPU) && cpu_req && dma_req;
  assign xfer_inc     = (owner_q == OWN_DMA) && dma_we && cpu_req;

  hold_counter #(.LIMIT(MAX_CPU_HOLD)) u_cpu_hold (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (owner_change),
    .inc_i      (cpu_inc),
    .at_limit_o (cpu_at_limit)
  );

  hold_counter #(.LIMIT(MAX_DMA_BURST)) u_xfer_hold (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (owner_change),
    .inc_i      (xfer_inc),
    .at_limit_o (xfer_at_limit)
  );

  assign cpu_grant = (owner_q == OWN_CPU) && cpu_req;
  assign dma_grant = (owner_q == OWN_DMA);
  assign cpu_stall = cpu_req && !cpu_grant;
  assign rdata     = ram_rdata;

  // RAM mux from the current owner; a stray dma_we from a non-owner
  // never reaches the RAM.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we && cpu_req;
      end
      OWN_DMA: begin
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        ram_we    = dma_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural bus model, a
// small DMAC model and a reference copy of the RAM.
module tb_ram_bus_arbiter;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 8;
  localparam int MAX_DMA_BURST = 4;
  localparam int MAX_CPU_HOLD  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req, dma_we, dma_grant;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, rdata;
  logic              ram_we;

  always #5 clk = ~clk;

  ram_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_DMA_BURST(MAX_DMA_BURST), .MAX_CPU_HOLD(MAX_CPU_HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_grant(dma_grant),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .rdata(rdata)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // RAM with asynchronous read
  logic [7:0] mem [256];
  logic       mem_load;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural bus model
  typedef enum {BUS_IDLE, BUS_CPU, BUS_DMA} bus_t;
  bus_t       m_own;
  int         m_cpu_held;    // cycles CPU held the bus while DMA waited
  int         m_dma_writes;  // DMA writes done while CPU waited
  logic [7:0] ref_mem [256];

  // DMAC model
  logic       dmac_on, stray_en;
  int         dmac_left;
  logic       dmac_phase;    // 0: read pending, 1: write pending
  logic [7:0] dmac_src, dmac_dst, dmac_data;

  // Observed outputs of the last cycle
  logic       o_cpu_gnt, o_dma_gnt, o_we, o_stall;
  logic [7:0] o_addr;

  task automatic dmac_launch(input logic [7:0] src, input logic [7:0] dst, input int n);
    dmac_src = src; dmac_dst = dst; dmac_left = n; dmac_phase = 1'b0;
  endtask

  task automatic dmac_drive();
    if (dmac_left > 0) begin
      // bus_req drops during the final write so the bus frees right after it
      dma_req   = !(dmac_phase && dmac_left == 1);
      dma_we    = dmac_phase;
      dma_addr  = dmac_phase ? dmac_dst : dmac_src;
      dma_wdata = dmac_data;
    end else begin
      dma_req   = 1'b0;
      dma_we    = stray_en ? 1'($urandom) : 1'b0;
      dma_addr  = stray_en ? 8'($urandom) : 8'h00;
      dma_wdata = stray_en ? 8'($urandom) : 8'h00;
    end
  endtask

  // One clock cycle: entered just after a falling edge with inputs set.
  task automatic tick();
    logic       e_cpu_gnt, e_dma_gnt, e_we, e_stall;
    logic [7:0] e_addr, e_wd;
    bus_t       nxt;
    if (dmac_on) dmac_drive();
    #1;
    e_cpu_gnt = (m_own == BUS_CPU) && cpu_req;
    e_dma_gnt = (m_own == BUS_DMA);
    e_stall   = cpu_req && !e_cpu_gnt;
    e_addr = 8'h00; e_wd = 8'h00; e_we = 1'b0;
    if (m_own == BUS_CPU) begin
      e_addr = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we && cpu_req;
    end else if (m_own == BUS_DMA) begin
      e_addr = dma_addr; e_wd = dma_wdata; e_we = dma_we;
    end
    check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("dma_grant", 32'(dma_grant), 32'(e_dma_gnt));
    check("ram_we",    32'(ram_we),    32'(e_we));
    check("ram_addr",  32'(ram_addr),  32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    check("rdata",     32'(rdata),     32'(mem[e_addr]));
    o_cpu_gnt = cpu_req && !cpu_stall;
    o_dma_gnt = dma_grant;
    o_we      = ram_we;
    o_addr    = ram_addr;
    o_stall   = cpu_stall;
    if (e_we) ref_mem[e_addr] = e_wd;
    // Who owns the bus after this edge
    nxt = m_own;
    if (rst) begin
      nxt = BUS_IDLE;
    end else if (m_own == BUS_IDLE) begin
      nxt = cpu_req ? BUS_CPU : (dma_req ? BUS_DMA : BUS_IDLE);
    end else if (m_own == BUS_CPU) begin
      if (!cpu_req) nxt = dma_req ? BUS_DMA : BUS_IDLE;
      else if (dma_req && m_cpu_held == MAX_CPU_HOLD - 1) nxt = BUS_DMA;
    end else begin
      if (!dma_req) nxt = cpu_req ? BUS_CPU : BUS_IDLE;
      else if (dma_we && cpu_req && m_dma_writes == MAX_DMA_BURST - 1) nxt = BUS_CPU;
    end
    if (rst || nxt != m_own) begin
      m_cpu_held = 0; m_dma_writes = 0;
    end else begin
      if (m_own == BUS_CPU && cpu_req && dma_req) m_cpu_held++;
      if (m_own == BUS_DMA && dma_we && cpu_req)  m_dma_writes++;
    end
    m_own = nxt;
    // DMAC advances only on cycles it actually held the bus
    if (rst) begin
      dmac_left = 0; dmac_phase = 1'b0;
    end else if (dmac_on && dmac_left > 0 && e_dma_gnt) begin
      if (!dmac_phase) begin
        dmac_data = ram_rdata; dmac_phase = 1'b1;
      end else begin
        dmac_src++; dmac_dst++; dmac_left--; dmac_phase = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt, writes, cpu_cycles, first, last, gcount;
    logic       seen, did_rst;
    logic [7:0] wq [$];

    rst = 1'b1; mem_load = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
    dmac_on = 1'b0; stray_en = 1'b0; dmac_left = 0; dmac_phase = 1'b0;
    dmac_src = 8'h00; dmac_dst = 8'h00; dmac_data = 8'h00;
    o_stall = 1'b0;
    m_own = BUS_IDLE; m_cpu_held = 0; m_dma_writes = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(negedge clk);
    mem_load = 1'b0;

    // 1: reset held with both requests -> nobody owns the bus
    tick();
    check("rst_dma_grant", 32'(o_dma_gnt), 0);
    check("rst_cpu_grant", 32'(o_cpu_gnt), 0);
    check("rst_cpu_stall", 32'(o_stall), 1);
    check("rst_ram_we",    32'(o_we), 0);
    rst = 1'b0;
    tick();
    check("post_rst_no_grant", 32'(o_cpu_gnt), 0);
    tick();
    check("post_rst_cpu_grant", 32'(o_cpu_gnt), 1);

    // 2: simultaneous requests from idle; CPU first, DMA after 8 cycles
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    check("simul_first_stall", 32'(o_stall), 1);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_cpu_gnt) cnt++;
      if (o_dma_gnt) seen = 1'b1;
    end
    check("cpu_hold_cycles", 32'(cnt), MAX_CPU_HOLD);
    check("dma_got_bus", 32'(seen), 1);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // 3: DMA copy 0x10->0x40 size 6 with CPU waiting from the start
    dmac_on = 1'b1;
    dmac_launch(8'h10, 8'h40, 6);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h80;
    writes = 0; cpu_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 100 && dmac_left > 0; i++) begin
      tick();
      if (o_dma_gnt && dma_we && !seen) writes++;
      if (o_cpu_gnt) begin
        if (!seen) check("writes_before_cpu", 32'(writes), MAX_DMA_BURST);
        seen = 1'b1;
        check("no_split_pair", 32'(dmac_phase), 0);
        cpu_cycles++;
        if (cpu_cycles == 3) cpu_req = 1'b0;
      end
    end
    check("copy_done", 32'(dmac_left), 0);
    check("cpu_got_bus", 32'(seen), 1);
    for (int i = 0; i < 6; i++) check("copy_data", 32'(mem[8'h40 + i]), 32'(init_val(8'h10 + i)));

    // 4: DMA alone, size 3
    cpu_req = 1'b0;
    dmac_launch(8'h30, 8'h40, 3);
    gcount = 0; first = -1; last = -1;
    for (int i = 0; i < 30 && dmac_left > 0; i++) begin
      tick();
      if (o_dma_gnt) begin
        gcount++;
        if (first < 0) first = i;
        last = i;
      end
      if (o_we) wq.push_back(o_addr);
    end
    tick();
    check("dma_alone_grants", 32'(gcount), 6);
    check("dma_alone_contig", 32'(last - first + 1), 6);
    check("dma_alone_release", 32'(o_dma_gnt), 0);
    check("dma_alone_nwrites", 32'(wq.size()), 3);
    for (int i = 0; i < 3 && i < wq.size(); i++) check("dma_alone_waddr", 32'(wq[i]), 32'(8'h40 + i));
    for (int i = 0; i < 3; i++) check("dma_alone_data", 32'(mem[8'h40 + i]), 32'(init_val(8'h30 + i)));

    // 5: CPU write to idle bus
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'hA5;
    tick();
    check("cpu_wr_stall0", 32'(o_stall), 1);
    check("cpu_wr_we0", 32'(o_we), 0);
    tick();
    check("cpu_wr_stall1", 32'(o_stall), 0);
    check("cpu_wr_we1", 32'(o_we), 1);
    check("cpu_wr_addr1", 32'(o_addr), 32'h20);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("cpu_wr_mem", 32'(mem[8'h20]), 32'hA5);

    // 6: reset in a DMA write cycle
    dmac_launch(8'h50, 8'h60, 4);
    tick();
    cpu_req = 1'b1; cpu_addr = 8'h81;
    writes = 0; did_rst = 1'b0;
    for (int i = 0; i < 20 && !did_rst; i++) begin
      if (dmac_phase && m_own == BUS_DMA && writes == 1) begin
        rst = 1'b1; did_rst = 1'b1;
      end
      tick();
      if (o_dma_gnt && dma_we) writes++;
    end
    check("rst_hit_write", 32'(did_rst), 1);
    rst = 1'b0;
    tick();
    check("rst_mid_dma_grant", 32'(o_dma_gnt), 0);
    check("rst_mid_we", 32'(o_we), 0);
    check("rst_mid_stall", 32'(o_stall), 1);
    check("rst_cpu_cnt", 32'(dut.u_cpu_hold.cnt_q), 0);
    check("rst_xfer_cnt", 32'(dut.u_xfer_hold.cnt_q), 0);
    tick();
    check("rst_then_cpu", 32'(o_cpu_gnt), 1);
    cpu_req = 1'b0;
    tick();
    check("rst_no_later_write", 32'(mem[8'h62]), 32'(init_val(8'h62)));

    // Randomized traffic with stray DMA writes and occasional resets
    stray_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!o_stall) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom);
        cpu_addr  = 8'($urandom);
        cpu_wdata = 8'($urandom);
      end
      if (dmac_left == 0 && $urandom_range(0, 5) == 0)
        dmac_launch(8'($urandom), 8'($urandom), int'($urandom_range(1, 6)));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; cpu_req = 1'b0; stray_en = 1'b0;
    for (int i = 0; i < 30 && dmac_left > 0; i++) tick();
    tick();
    for (int i = 0; i < 256; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
